// File: rtl/jtframe_objdraw_pkg.sv
// Shared types and constants for the object line renderer.
//   st_e    : renderer FSM states
//   obj_t   : decoded object table entry
//   OBJ_*   : field offsets/widths inside the 32-bit object table word
package jtframe_objdraw_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SCAN,
        ST_CHECK,
        ST_FETCH,
        ST_DRAW,
        ST_DONE
    } st_e;

    localparam int unsigned OBJ_X_LSB     = 0;
    localparam int unsigned OBJ_X_W       = 9;
    localparam int unsigned OBJ_Y_LSB     = 9;
    localparam int unsigned OBJ_Y_W       = 8;
    localparam int unsigned OBJ_CODE_LSB  = 17;
    localparam int unsigned OBJ_CODE_W    = 10;
    localparam int unsigned OBJ_PAL_LSB   = 27;
    localparam int unsigned OBJ_PAL_W     = 4;
    localparam int unsigned OBJ_HFLIP_BIT = 31;

    localparam int unsigned OBJ_SIZE      = 16;
    localparam int unsigned PXL_PER_WORD  = 8;
    localparam int unsigned PXL_BITS      = 4;
    localparam int unsigned PXL_CNT_W     = 3;
    localparam int unsigned ROW_W         = 4;
    localparam int unsigned ROM_AW        = OBJ_CODE_W + ROW_W + 1;
    localparam int unsigned ROM_DW        = PXL_BITS * PXL_PER_WORD;

    typedef struct packed {
        logic                  hflip;
        logic [OBJ_PAL_W-1:0]  pal;
        logic [OBJ_CODE_W-1:0] code;
        logic [OBJ_Y_W-1:0]    y;
        logic [OBJ_X_W-1:0]    x;
    } obj_t;

    // Split a raw object table word into its fields.
    function automatic obj_t obj_decode(input logic [31:0] d);
        obj_t o;
        o.x     = d[OBJ_X_LSB    +: OBJ_X_W];
        o.y     = d[OBJ_Y_LSB    +: OBJ_Y_W];
        o.code  = d[OBJ_CODE_LSB +: OBJ_CODE_W];
        o.pal   = d[OBJ_PAL_LSB  +: OBJ_PAL_W];
        o.hflip = d[OBJ_HFLIP_BIT];
        return o;
    endfunction

endpackage

// File: rtl/jtframe_objdraw_pxl.sv
// 8-pixel shifter for one ROM word.
//   i_load/i_data/i_hflip : capture a 32-bit word (pixel 0 in [3:0]) and its flip mode
//   i_shift               : advance to the next pixel
//   o_col_c/o_opaque_c    : current pixel colour and non-transparent flag
// With hflip the word is walked from pixel 7 down to pixel 0.
module jtframe_objdraw_pxl
    import jtframe_objdraw_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_load,
    input  logic                i_shift,
    input  logic                i_hflip,
    input  logic [ROM_DW-1:0]   i_data,
    output logic [PXL_BITS-1:0] o_col_c,
    output logic                o_opaque_c
);

    logic [ROM_DW-1:0] r_data;
    logic              r_hflip;

    // Pixel word register; shift direction picks the emission order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_hflip <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_hflip <= i_hflip;
        end else if (i_shift) begin
            if (r_hflip) r_data <= {r_data[ROM_DW-PXL_BITS-1:0], PXL_BITS'(0)};
            else         r_data <= {PXL_BITS'(0), r_data[ROM_DW-1:PXL_BITS]};
        end
    end

    assign o_col_c    = r_hflip ? r_data[ROM_DW-1 -: PXL_BITS] : r_data[PXL_BITS-1:0];
    assign o_opaque_c = |o_col_c;

endmodule

// File: rtl/jtframe_lfbuf_objdraw.sv
// Object line renderer feeding the line/frame buffer.
//   ln_hs/ln_v            : start rendering line ln_v
//   ln_addr/ln_data/ln_we : line buffer write port (clear, then opaque object pixels)
//   ln_done/busy/ovf      : completion pulse, activity flag, restart-while-busy pulse
//   obj_addr/obj_data     : object table, synchronous read with one clock latency
//   rom_addr/rom_cs/rom_ok/rom_data : graphics ROM, request held until rom_ok
module jtframe_lfbuf_objdraw
    import jtframe_objdraw_pkg::*;
#(
    parameter int unsigned   DW    = 16,
    parameter int unsigned   VW    = 8,
    parameter int unsigned   HW    = 9,
    parameter int unsigned   HLEN  = 256,
    parameter int unsigned   OBJW  = 6,
    parameter logic [DW-1:0] BGCOL = '0
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ln_hs,
    input  logic [VW-1:0]     ln_v,
    output logic [HW-1:0]     ln_addr,
    output logic [DW-1:0]     ln_data,
    output logic              ln_we,
    output logic              ln_done,
    output logic [OBJW-1:0]   obj_addr,
    input  logic [31:0]       obj_data,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              rom_cs,
    input  logic              rom_ok,
    input  logic [31:0]       rom_data,
    output logic              busy,
    output logic              ovf
);

    // one extra bit so x + offset never wraps back into the visible line
    localparam int unsigned PW = OBJ_X_W + 1;

    st_e                   r_st, w_st;
    logic [OBJ_Y_W-1:0]    r_line, w_line;
    logic [OBJW-1:0]       r_idx, w_idx;
    logic [HW-1:0]         r_cnt, w_cnt;
    logic [PXL_CNT_W-1:0]  r_pix, w_pix;
    logic                  r_half, w_half;
    logic [OBJ_X_W-1:0]    r_x, w_x;
    logic [OBJ_CODE_W-1:0] r_code, w_code;
    logic [OBJ_PAL_W-1:0]  r_pal, w_pal;
    logic                  r_hflip, w_hflip;
    logic [ROW_W-1:0]      r_row, w_rowl;
    logic [HW-1:0]         r_ln_addr, w_ln_addr;
    logic [DW-1:0]         r_ln_data, w_ln_data;
    logic                  r_ln_we, w_ln_we;
    logic                  r_ln_done, w_ln_done;
    logic [ROM_AW-1:0]     r_rom_addr, w_rom_addr;
    logic                  r_rom_cs, w_rom_cs;
    logic                  r_busy, w_busy;
    logic                  r_ovf, w_ovf;

    obj_t                  w_obj;
    logic [OBJ_Y_W-1:0]    w_row;
    logic [PW-1:0]         w_px;
    logic                  w_load, w_shift, w_opaque;
    logic [PXL_BITS-1:0]   w_col;

    assign w_obj = obj_decode(obj_data);
    assign w_row = r_line - w_obj.y;
    assign w_px  = PW'(r_x) + PW'({r_half, r_pix});

    jtframe_objdraw_pxl u_pxl (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_shift    (w_shift),
        .i_hflip    (r_hflip),
        .i_data     (rom_data),
        .o_col_c    (w_col),
        .o_opaque_c (w_opaque)
    );

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st       <= ST_IDLE;
            r_line     <= '0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_pix      <= '0;
            r_half     <= 1'b0;
            r_x        <= '0;
            r_code     <= '0;
            r_pal      <= '0;
            r_hflip    <= 1'b0;
            r_row      <= '0;
            r_ln_addr  <= '0;
            r_ln_data  <= '0;
            r_ln_we    <= 1'b0;
            r_ln_done  <= 1'b0;
            r_rom_addr <= '0;
            r_rom_cs   <= 1'b0;
            r_busy     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_st       <= w_st;
            r_line     <= w_line;
            r_idx      <= w_idx;
            r_cnt      <= w_cnt;
            r_pix      <= w_pix;
            r_half     <= w_half;
            r_x        <= w_x;
            r_code     <= w_code;
            r_pal      <= w_pal;
            r_hflip    <= w_hflip;
            r_row      <= w_rowl;
            r_ln_addr  <= w_ln_addr;
            r_ln_data  <= w_ln_data;
            r_ln_we    <= w_ln_we;
            r_ln_done  <= w_ln_done;
            r_rom_addr <= w_rom_addr;
            r_rom_cs   <= w_rom_cs;
            r_busy     <= w_busy;
            r_ovf      <= w_ovf;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_st       = r_st;
        w_line     = r_line;
        w_idx      = r_idx;
        w_cnt      = r_cnt;
        w_pix      = r_pix;
        w_half     = r_half;
        w_x        = r_x;
        w_code     = r_code;
        w_pal      = r_pal;
        w_hflip    = r_hflip;
        w_rowl     = r_row;
        w_ln_addr  = r_ln_addr;
        w_ln_data  = r_ln_data;
        w_ln_we    = 1'b0;
        w_ln_done  = 1'b0;
        w_rom_addr = r_rom_addr;
        w_rom_cs   = r_rom_cs;
        w_busy     = r_busy;
        w_ovf      = 1'b0;
        w_load     = 1'b0;
        w_shift    = 1'b0;

        case (r_st)
            ST_IDLE: ;
            ST_CLEAR: begin
                w_ln_we   = 1'b1;
                w_ln_data = BGCOL;
                w_ln_addr = r_cnt;
                w_cnt     = r_cnt + HW'(1);
                if (r_cnt == HW'(HLEN - 1)) w_st = ST_SCAN;
            end
            // obj_addr is r_idx itself, so the table word arrives in CHECK
            ST_SCAN: w_st = ST_CHECK;
            ST_CHECK: begin
                if (w_row < OBJ_Y_W'(OBJ_SIZE)) begin
                    w_x        = w_obj.x;
                    w_code     = w_obj.code;
                    w_pal      = w_obj.pal;
                    w_hflip    = w_obj.hflip;
                    w_rowl     = w_row[ROW_W-1:0];
                    w_half     = 1'b0;
                    w_rom_cs   = 1'b1;
                    // flipped objects start from the right-hand ROM half
                    w_rom_addr = {w_obj.code, w_row[ROW_W-1:0], w_obj.hflip};
                    w_st       = ST_FETCH;
                end else if (r_idx == '1) begin
                    w_st = ST_DONE;
                end else begin
                    w_idx = r_idx + OBJW'(1);
                    w_st  = ST_SCAN;
                end
            end
            ST_FETCH: begin
                if (rom_ok) begin
                    w_rom_cs = 1'b0;
                    w_load   = 1'b1;
                    w_pix    = '0;
                    w_st     = ST_DRAW;
                end
            end
            ST_DRAW: begin
                w_shift   = 1'b1;
                w_ln_we   = w_opaque && (w_px < PW'(HLEN));
                w_ln_addr = HW'(w_px);
                w_ln_data = DW'({r_pal, w_col});
                w_pix     = r_pix + PXL_CNT_W'(1);
                if (r_pix == PXL_CNT_W'(PXL_PER_WORD - 1)) begin
                    if (!r_half) begin
                        w_half     = 1'b1;
                        w_rom_cs   = 1'b1;
                        w_rom_addr = {r_code, r_row, ~r_hflip};
                        w_st       = ST_FETCH;
                    end else if (r_idx == '1) begin
                        w_st = ST_DONE;
                    end else begin
                        w_idx = r_idx + OBJW'(1);
                        w_st  = ST_SCAN;
                    end
                end
            end
            ST_DONE: begin
                w_ln_done = 1'b1;
                w_busy    = 1'b0;
                w_st      = ST_IDLE;
            end
            default: w_st = ST_IDLE;
        endcase

        // A new line always wins; a line already in DONE still reports completion.
        if (ln_hs) begin
            w_ovf    = (r_st != ST_IDLE) && (r_st != ST_DONE);
            w_st     = ST_CLEAR;
            w_line   = OBJ_Y_W'(ln_v);
            w_cnt    = '0;
            w_idx    = '0;
            w_busy   = 1'b1;
            w_rom_cs = 1'b0;
            w_ln_we  = 1'b0;
            w_load   = 1'b0;
            w_shift  = 1'b0;
        end
    end

    assign ln_addr  = r_ln_addr;
    assign ln_data  = r_ln_data;
    assign ln_we    = r_ln_we;
    assign ln_done  = r_ln_done;
    assign obj_addr = r_idx;
    assign rom_addr = r_rom_addr;
    assign rom_cs   = r_rom_cs;
    assign busy     = r_busy;
    assign ovf      = r_ovf;

endmodule

// File: tb/tb_jtframe_lfbuf_objdraw.sv
// Scoreboard bench for jtframe_lfbuf_objdraw: expected line writes and ROM
// requests are queued by the stimulus, a negedge monitor pops and compares.
module tb_jtframe_lfbuf_objdraw;

    logic        clk;
    logic        rst_n;
    logic        ln_hs;
    logic [7:0]  ln_v;
    logic [8:0]  ln_addr;
    logic [15:0] ln_data;
    logic        ln_we;
    logic        ln_done;
    logic [5:0]  obj_addr;
    logic [31:0] obj_data;
    logic [14:0] rom_addr;
    logic        rom_cs;
    logic        rom_ok;
    logic [31:0] rom_data;
    logic        busy;
    logic        ovf;

    jtframe_lfbuf_objdraw dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ln_hs    (ln_hs),
        .ln_v     (ln_v),
        .ln_addr  (ln_addr),
        .ln_data  (ln_data),
        .ln_we    (ln_we),
        .ln_done  (ln_done),
        .obj_addr (obj_addr),
        .obj_data (obj_data),
        .rom_addr (rom_addr),
        .rom_cs   (rom_cs),
        .rom_ok   (rom_ok),
        .rom_data (rom_data),
        .busy     (busy),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [24:0] wq[$];
    logic [14:0] rq[$];
    int          done_seen = 0;
    int          ovf_seen  = 0;
    int          cs_cnt    = 0;
    logic        mon_en    = 1'b0;
    int          rom_lat   = 0;
    int          rom_cnt   = 0;
    logic        r_rom_ok  = 1'b0;
    logic        rom_stray = 1'b0;
    logic [31:0] obj_mem [64];
    logic [3:0]  pat [16];
    logic [24:0] e_w;
    logic [14:0] e_r;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    function automatic logic [31:0] mk_obj(input logic hf, input logic [3:0] pal,
                                           input logic [9:0] code, input logic [7:0] y,
                                           input logic [8:0] x);
        return {hf, pal, code, y, x};
    endfunction

    // Object table: synchronous RAM, one clock latency.
    always @(posedge clk) obj_data <= obj_mem[obj_addr];

    // ROM: rom_ok rises rom_lat+1 clocks after rom_cs; half 0/1 return fixed words.
    always @(posedge clk) begin
        if (!rom_cs || r_rom_ok) begin
            rom_cnt  <= 0;
            r_rom_ok <= 1'b0;
        end else begin
            rom_cnt <= rom_cnt + 1;
            if (rom_cnt >= rom_lat) begin
                r_rom_ok <= 1'b1;
                rom_data <= rom_addr[0] ? 32'hFED0_BA98 : 32'h0765_4321;
            end
        end
    end
    assign rom_ok = r_rom_ok | rom_stray;

    // Monitor
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (ln_we) begin
                if (wq.size() == 0) begin
                    n_chk++;
                    $display("FAIL extra_write: addr %0d data %0h, none expected", ln_addr, ln_data);
                end else begin
                    e_w = wq.pop_front();
                    chk("write", 64'({ln_addr, ln_data}), 64'(e_w));
                end
            end
            cs_cnt = rom_cs ? cs_cnt + 1 : 0;
            if (rom_cs && rom_ok) begin
                if (rq.size() == 0) begin
                    n_chk++;
                    $display("FAIL extra_rom: addr %0h, none expected", rom_addr);
                end else begin
                    e_r = rq.pop_front();
                    chk("rom_addr", 64'(rom_addr), 64'(e_r));
                    chk("rom_cs_hold", 64'(cs_cnt), 64'(rom_lat + 2));
                end
                cs_cnt = 0;
            end
            if (ln_done) done_seen++;
            if (ovf) ovf_seen++;
        end
    end

    task automatic push_clear();
        for (int a = 0; a < 256; a++) wq.push_back({9'(a), 16'h0000});
    endtask

    // Hand-listed pixel table: position x+k gets pat[k] (pat[15-k] if flipped).
    task automatic push_obj(input int x, input logic [3:0] pal, input logic hf);
        logic [3:0] c;
        for (int k = 0; k < 16; k++) begin
            c = hf ? pat[15-k] : pat[k];
            if (c != 4'h0 && x + k < 256) wq.push_back({9'(x + k), 8'h00, pal, c});
        end
    endtask

    task automatic pulse_hs(input logic [7:0] v);
        @(posedge clk); #1 ln_v = v; ln_hs = 1'b1;
        @(posedge clk); #1 ln_hs = 1'b0;
        chk("busy_set", 64'(busy), 64'd1);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!ln_done && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_seen", 64'(ln_done), 64'd1);
    endtask

    task automatic line_end(input int d0, input int o0, input int exp_ovf);
        repeat (3) @(posedge clk);
        #1;
        chk("wq_drained", 64'(wq.size()), 64'd0);
        chk("rq_drained", 64'(rq.size()), 64'd0);
        chk("done_count", 64'(done_seen - d0), 64'd1);
        chk("ovf_count", 64'(ovf_seen - o0), 64'(exp_ovf));
        chk("busy_idle", 64'(busy), 64'd0);
    endtask

    task automatic clear_table();
        for (int i = 0; i < 64; i++) obj_mem[i] = mk_obj(1'b0, 4'h0, 10'd0, 8'hF0, 9'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, d0, o0, w;
        pat = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h0,
                4'h8, 4'h9, 4'hA, 4'hB, 4'h0, 4'hD, 4'hE, 4'hF};
        rom_data = '0;
        ln_hs    = 1'b0;
        ln_v     = '0;
        clear_table();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({ln_addr, ln_data, ln_we, ln_done, obj_addr,
                                  rom_addr, rom_cs, busy, ovf}), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        mon_en = 1'b1;

        // Empty table, stray rom_ok held high throughout
        d0 = done_seen; o0 = ovf_seen;
        push_clear();
        rom_stray = 1'b1;
        pulse_hs(8'h10);
        wait_done(n);
        chk("empty_done_latency_ok", 64'(n >= 384 && n <= 392), 64'd1);
        rom_stray = 1'b0;
        line_end(d0, o0, 0);

        // Single object, no flip
        obj_mem[0] = mk_obj(1'b0, 4'd3, 10'd5, 8'h0C, 9'd20);
        d0 = done_seen; o0 = ovf_seen;
        rom_lat = 0;
        push_clear();
        push_obj(20, 4'd3, 1'b0);
        rq.push_back({10'd5, 4'd4, 1'b0});
        rq.push_back({10'd5, 4'd4, 1'b1});
        pulse_hs(8'h10);
        wait_done(n);
        line_end(d0, o0, 0);

        // Same object flipped, slow ROM
        obj_mem[0] = mk_obj(1'b1, 4'd3, 10'd5, 8'h0C, 9'd20);
        d0 = done_seen; o0 = ovf_seen;
        rom_lat = 5;
        push_clear();
        push_obj(20, 4'd3, 1'b1);
        rq.push_back({10'd5, 4'd4, 1'b1});
        rq.push_back({10'd5, 4'd4, 1'b0});
        pulse_hs(8'h10);
        wait_done(n);
        line_end(d0, o0, 0);

        // Right-edge clipping with row wrap, plus the last table entry on top
        obj_mem[0]  = mk_obj(1'b0, 4'd1, 10'd7, 8'hFC, 9'd250);
        obj_mem[63] = mk_obj(1'b0, 4'd2, 10'd9, 8'h02, 9'd248);
        d0 = done_seen; o0 = ovf_seen;
        rom_lat = 1;
        push_clear();
        push_obj(250, 4'd1, 1'b0);
        push_obj(248, 4'd2, 1'b0);
        rq.push_back({10'd7, 4'd6, 1'b0});
        rq.push_back({10'd7, 4'd6, 1'b1});
        rq.push_back({10'd9, 4'd0, 1'b0});
        rq.push_back({10'd9, 4'd0, 1'b1});
        pulse_hs(8'h02);
        wait_done(n);
        line_end(d0, o0, 0);

        // Second ln_hs during SCAN restarts the line
        clear_table();
        d0 = done_seen; o0 = ovf_seen;
        push_clear();
        push_clear();
        pulse_hs(8'h10);
        repeat (300) @(posedge clk);
        pulse_hs(8'h10);
        wait_done(n);
        line_end(d0, o0, 1);

        // Reset in the middle of DRAW, then a normal line
        obj_mem[0] = mk_obj(1'b0, 4'd3, 10'd5, 8'h0C, 9'd20);
        rom_lat = 0;
        mon_en  = 1'b0;
        pulse_hs(8'h10);
        w = 0;
        while (!(rom_cs && rom_ok) && w < 1000) begin
            @(posedge clk); #1;
            w++;
        end
        chk("fetch_reached", 64'(rom_cs && rom_ok), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("busy_mid_draw", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_draw", 64'({ln_addr, ln_data, ln_we, ln_done, obj_addr,
                                   rom_addr, rom_cs, busy, ovf}), 64'd0);
        repeat (2) @(posedge clk);
        wq.delete();
        rq.delete();
        @(negedge clk) rst_n = 1'b1;
        mon_en = 1'b1;
        d0 = done_seen; o0 = ovf_seen;
        push_clear();
        push_obj(20, 4'd3, 1'b0);
        rq.push_back({10'd5, 4'd4, 1'b0});
        rq.push_back({10'd5, 4'd4, 1'b1});
        pulse_hs(8'h10);
        wait_done(n);
        line_end(d0, o0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
